// File: rtl/uart_rx_if.sv
// Register bus between a host and the uart_rx slave.
// Single-cycle accesses: i_cyc qualifies each access, i_we selects write or read, o_dat returns read data.
interface uart_rx_if;
    logic       i_addr;
    logic [7:0] i_dat;
    logic [7:0] o_dat;
    logic       i_we;
    logic       i_cyc;

    modport slave  (input  i_addr, i_dat, i_we, i_cyc, output o_dat);
    modport master (output i_addr, i_dat, i_we, i_cyc, input  o_dat);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a DATA/STATUS register slave and a per-frame interrupt pulse.
// Define UART_RX_MAJORITY_EN to make each bit decision a 2-of-3 majority vote around mid-bit.
module uart_rx #(
    parameter int SYS_CLK  = 50_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic         i_clk,
    input  logic         i_reset,
    uart_rx_if.slave     bus,
    input  logic         rx,
    output logic         o_int
);
    localparam int TICK = SYS_CLK / BAUDRATE;
    localparam int HALF = TICK / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    // Voting delays each decision by LAG cycles; reloading the counter with LAG keeps later bits on the start-edge grid.
    localparam logic [15:0] START_AT   = 16'(HALF - 1 + LAG);
    localparam logic [15:0] BIT_AT     = 16'(TICK - 1 + LAG);
    localparam logic [15:0] CNT_RELOAD = 16'(LAG);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic        rx_m, rx_s;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift, rx_data;
    logic        ready, overrun, ferr;
    logic        bit_val, start_hit, bit_hit, commit, frame_err, rd_data, wr_stat, active;
    logic        unused_dat_bits;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = maj3(rx_s, rx_d1, rx_d2);
`else
    assign bit_val = rx_s;
`endif

    assign start_hit = (state == S_START) && (cnt == START_AT);
    assign bit_hit   = ((state == S_DATA) || (state == S_STOP)) && (cnt == BIT_AT);
    assign commit    = (state == S_STOP) && bit_hit && bit_val;
    assign frame_err = (state == S_STOP) && bit_hit && !bit_val;
    assign rd_data   = bus.i_cyc && !bus.i_we && !bus.i_addr;
    assign wr_stat   = bus.i_cyc && bus.i_we && bus.i_addr;
    assign active    = (state != S_IDLE);
    assign unused_dat_bits = ^{bus.i_dat[7:3], bus.i_dat[0]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (start_hit) begin
                        if (!bit_val) begin
                            state   <= S_DATA;
                            cnt     <= CNT_RELOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_hit) begin
                        shift[bit_idx] <= bit_val;
                        cnt            <= CNT_RELOAD;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_hit) begin
                        state <= bit_val ? S_IDLE : S_BREAK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_BREAK: begin
                    // Hold here while the line stays low so a break cannot start a new frame.
                    cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_data <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
            o_int   <= 1'b0;
        end else begin
            o_int <= commit | frame_err;
            // A commit beats a same-cycle DATA read; that read consumed the old byte, so no overrun.
            if (commit) begin
                rx_data <= shift;
                ready   <= 1'b1;
                overrun <= ready & ~rd_data;
            end else if (rd_data) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end else if (wr_stat && bus.i_dat[1]) begin
                overrun <= 1'b0;
            end
            if (frame_err)                    ferr <= 1'b1;
            else if (wr_stat && bus.i_dat[2]) ferr <= 1'b0;
        end
    end

    assign bus.o_dat = bus.i_addr ? {4'b0000, active, ferr, overrun, ready} : rx_data;
endmodule
